// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues a request-to-send, then shifts one command byte
// (data LSB first, odd parity, stop) out on device-generated falling clock
// edges and checks the device ACK. The line drivers are open-drain enables:
// oe=1 pulls the line low, oe=0 releases it.
//
// Handshake: a byte is accepted on any clk edge where tx_valid and tx_ready
// are both high. tx_ready is high only in IDLE. tx_valid seen in any other
// state is ignored and nothing is queued. Exactly one of tx_done (ACK
// received and bus back to idle) or tx_error (NACK or timeout) pulses for
// one cycle per accepted byte, unless reset aborts the frame first.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int START_TIMEOUT  = 750000,
    parameter int FRAME_TIMEOUT  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        WAIT_CLK  = 3'd3,
        SEND      = 3'd4,
        ACK       = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

    // Terminal counts: a phase of N cycles ends on the cycle where cnt == N-1.
    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] REQ_LAST     = 20'(REQ_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] FRAME_LAST   = 20'(FRAME_TIMEOUT - 1);
    localparam logic [19:0] CNT_MAX      = 20'hF_FFFF;

    state_t      state;
    state_t      state_nx;
    logic [19:0] cnt;       // phase timer, reused as the frame timer after the first edge
    logic [3:0]  bit_idx;   // index of the bit currently driven in SEND
    logic [9:0]  frame;     // {stop, parity, data[7:0]}

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic clk_fall;

    logic accept;
    logic cnt_clr;
    logic bit_adv;
    logic err_evt;
    logic done_evt;

    // Two-flop synchronizers plus one history flop for edge detection; idle-high reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_i;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_i;
            dat_sync <= dat_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; an edge always wins over a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cnt_clr  = 1'b0;
        bit_adv  = 1'b0;
        err_evt  = 1'b0;
        done_evt = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    accept   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt >= INHIBIT_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (cnt >= REQ_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = WAIT_CLK;
                end
            end
            WAIT_CLK: begin
                if (clk_fall) begin
                    cnt_clr  = 1'b1;
                    state_nx = SEND;
                end else if (cnt >= START_LAST) begin
                    err_evt = 1'b1;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    if (bit_idx == 4'd8) begin
                        state_nx = ACK;
                    end else begin
                        bit_adv = 1'b1;
                    end
                end else if (cnt >= FRAME_LAST) begin
                    err_evt = 1'b1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (!dat_sync) begin
                        state_nx = WAIT_IDLE;
                    end else begin
                        err_evt = 1'b1;
                    end
                end else if (cnt >= FRAME_LAST) begin
                    err_evt = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    done_evt = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (err_evt) begin
            state_nx = IDLE;
        end
    end

    // Datapath: saturating timer, bit pointer, latched frame and result pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            frame    <= '0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_done  <= done_evt;
            tx_error <= err_evt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 20'd1;
            end
            if (accept) begin
                frame   <= {1'b1, ~^tx_data, tx_data};
                bit_idx <= '0;
            end else if (bit_adv) begin
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

    // Moore outputs: line enables and handshake flags decoded from state.
    always_comb begin
        tx_ready   = (state == IDLE);
        busy       = (state != IDLE);
        ps2_clk_oe = (state == INHIBIT) || (state == REQ);
        ps2_dat_oe = 1'b0;
        case (state)
            REQ, WAIT_CLK: ps2_dat_oe = 1'b1;
            SEND:          ps2_dat_oe = ~frame[bit_idx];
            default:       ps2_dat_oe = 1'b0;
        endcase
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter REQ_CYCLES, default 50: clock-and-data-low overlap time before the clock is released.
REQ-003 SHALL have parameter START_TIMEOUT, default 750000: cycles allowed from clock release to the first device falling edge (15 ms).
REQ-004 SHALL have parameter FRAME_TIMEOUT, default 100000: cycles allowed from the first device falling edge to ACK sampling (2 ms).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  system clock, 50 MHz global clock domain.
- rst  in  1  reset; synchronous, active-low.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid and tx_ready are both high.
- tx_ready  out  1  idle, can accept a byte.
- tx_done  out  1  one-cycle pulse; device ACKed and lines returned idle.
- tx_error  out  1  one-cycle pulse; NACK or timeout.
- busy  out  1  high in every state except IDLE; the receiver ignores the bus while busy.
- ps2_clk_i  in  1  PS/2 clock line level, asynchronous.
- ps2_dat_i  in  1  PS/2 data line level, asynchronous.
- ps2_clk_oe  out  1  1 = drive clock line low, 0 = release.
- ps2_dat_oe  out  1  1 = drive data line low, 0 = release.

Function
REQ-006 SHALL pass ps2_clk_i and ps2_dat_i through 2-flop synchronizers; a falling edge is synchronized previous=1, current=0, flagged for one cycle.
REQ-007 SHALL implement states IDLE, INHIBIT, REQ, WAIT_CLK, SEND, ACK, WAIT_IDLE.
REQ-008 IDLE: tx_ready=1, both oe=0; on accept, latch tx_data and odd parity (~^tx_data), clear counter -> INHIBIT.
REQ-009 INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
REQ-010 REQ: clk_oe=1, dat_oe=1 (start bit) for exactly REQ_CYCLES cycles -> WAIT_CLK; clk_oe=0 from the first WAIT_CLK cycle.
REQ-011 WAIT_CLK: dat_oe=1; first falling edge -> SEND and drive data bit0; START_TIMEOUT cycles with no edge -> error.
REQ-012 SEND: on each falling edge drive the next bit of {stop=1, parity, data[7:0]}, LSB first, dat_oe = ~bit; edges 1-8 drive data, edge 9 parity, edge 10 stop (dat_oe=0) -> ACK.
REQ-013 ACK: on edge 11 sample synchronized data; 0 -> WAIT_IDLE; 1 -> error.
REQ-014 WAIT_IDLE: both oe=0; when both synchronized lines are high, pulse tx_done -> IDLE.
REQ-015 SHALL run a frame counter from the first falling edge; reaching FRAME_TIMEOUT before ACK sampling -> error.
REQ-016 Error action: both oe=0 in the same cycle, one-cycle tx_error pulse, -> IDLE; tx_done is not asserted.
REQ-017 tx_valid outside IDLE SHALL be ignored, with no queuing.
REQ-018 SHALL ignore a falling edge in IDLE, INHIBIT or REQ.
REQ-019 An edge and a timeout in the same cycle SHALL give precedence to the edge.
REQ-020 Counters SHALL be 20 bits, saturating; no wrap-around.
REQ-021 tx_done and tx_error SHALL never be high in the same cycle.

Reset
REQ-022 When rst=0 at a clk edge, the block SHALL enter IDLE with ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1, counters and shift register cleared.
REQ-023 Reset mid-frame SHALL release both lines on the next clk edge, with no tx_done or tx_error pulse.
REQ-024 Synchronizer flops SHALL reset to 1 (idle-high bus).

Verification
REQ-025 Send 0xED, device model clocks at 12.5 kHz and ACKs:
- clk_oe low for 5000 cycles; start bit 0.
- Data line carries 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
- Exactly one tx_done pulse.
REQ-026 Send 0xF4 -> parity bit 0; send 0x00 -> parity 1; send 0xFF -> parity 1; each gets tx_done.
REQ-027 Device holds data high at edge 11 (NACK) -> one tx_error pulse, no tx_done, both oe=0, tx_ready=1 on the next cycle.
REQ-028 Device never clocks after release -> tx_error exactly START_TIMEOUT cycles after entering WAIT_CLK.
REQ-029 Device stops clocking after edge 5 -> tx_error when FRAME_TIMEOUT expires.
REQ-030 Two further cases:
- rst=0 during SEND bit 4 -> both oe=0 next cycle, no pulses.
- A new tx_valid with 0x55 is then accepted normally.
